systolic_mm_engine: RTL and testbench
=====================================

SYSTOLIC_MM_ENGINE -- requirements
Module: systolic_mm_engine

Interface
REQ-001 Parameter N, default 4, array dimension (NxN PEs, N >= 2).
REQ-002 Parameter DW, default 8, operand width.
REQ-003 Parameter CW, default 16, saturated output element width.
REQ-004 Parameter KW, default 8, width of k_len (max K = 2^KW-1).
REQ-005 Localparam ACCW = 2*DW+KW+1, accumulator width.
REQ-006 clk  in  1  single clock; all logic rising-edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 start  in  1  job request, sampled in IDLE only.
REQ-009 k_len  in  KW  inner dimension K, captured on accepted start.
REQ-010 signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; captured on accepted start.
REQ-011 in_valid  in  1  operand beat valid.
REQ-012 in_ready  out  1  operand beat accepted when in_valid & in_ready.
REQ-013 a_data  in  N*DW  A column k: lane i = A[i][k] at bits [i*DW +: DW].
REQ-014 b_data  in  N*DW  B row k: lane j = B[k][j] at bits [j*DW +: DW].
REQ-015 out_valid  out  1  result row valid.
REQ-016 out_ready  in  1  result row accepted when out_valid & out_ready.
REQ-017 out_data  out  N*CW  row r of C: lane j = sat(C[r][j]) at [j*CW +: CW].
REQ-018 out_row  out  clog2(N)  row index of out_data.
REQ-019 out_last  out  1  high with row N-1.
REQ-020 busy  out  1  high whenever state != IDLE.
REQ-021 done  out  1  one-cycle pulse at job completion.
REQ-022 sat_flag  out  1  sticky per job: any drained element saturated.

Function
REQ-023 FSM states SHALL be IDLE, LOAD, FLUSH, DRAIN.
- IDLE -> LOAD on start with k_len != 0; IDLE -> DRAIN on start with k_len == 0.
REQ-024 On accepted start: all accumulators, skew registers, beat counter and sat_flag cleared; k_len and signed_mode latched.
REQ-025 in_ready SHALL be 1 only in LOAD.
- Exactly K beats accepted; in_valid gaps insert bubbles with no effect on results.
- Transition to FLUSH in the cycle after the K-th handshake.
REQ-026 Internal input skew: lane i of a_data delayed i cycles before PE(i,0); lane j of b_data delayed j cycles before PE(0,j); each operand carries its valid bit.
REQ-027 Each PE SHALL register a/b and valids to its right/lower neighbour (1 cycle per hop).
- Accumulates a*b (sign- or zero-extended to ACCW per signed_mode) only when both incoming valids are 1.
REQ-028 FLUSH SHALL last exactly 2N cycles, then enter DRAIN; all PE products have landed by then.
REQ-029 DRAIN presents rows r = 0..N-1 in order; out_valid = 1 throughout DRAIN.
- out_data/out_row stable while out_ready = 0.
- Row advances on handshake.
REQ-030 Saturation:
- signed mode: clamp to [-2^(CW-1), 2^(CW-1)-1].
- unsigned mode: clamp to [0, 2^CW-1].
- Otherwise low CW bits.
REQ-031 sat_flag set when a handshaken row contains a clamped element; holds until next accepted start.
REQ-032 After row N-1 handshake: next state IDLE, done = 1 for that one cycle, busy = 0 in that cycle.
REQ-033 start while busy SHALL be ignored (no relatch, no clear).
REQ-034 Accumulators SHALL not wrap for any K <= 2^KW-1 (guaranteed by ACCW).

Reset
REQ-035 rst in any state: state IDLE, in_ready=0, out_valid=0, out_last=0, out_row=0, out_data=0, busy=0, done=0, sat_flag=0, accumulators/skew registers/valids cleared, effective next cycle; in-flight job discarded.

Verification
REQ-036 N=4, signed, K=4, A=identity, B[k][j]=k*4+j, no gaps, out_ready=1 -> rows out = B rows, out_last on row 3, done pulse, sat_flag=0.
REQ-037 Signed, K=4, all operands 127 -> every element 0x7FFF, sat_flag=1; all operands -128 x 127 -> 0x8000, sat_flag=1.
REQ-038 Unsigned, K=1, all 255 -> every element 0xFE01, sat_flag=0.
REQ-039 K=3 with in_valid low every other cycle and out_ready low 5 cycles on row 1 -> results identical to gap-free run; row 1 data held stable.
REQ-040 rst mid-LOAD after 2 beats, then new job K=2 -> results reflect only new job; start pulsed during FLUSH ignored.
REQ-041 k_len=0 -> FLUSH and LOAD skipped, four rows of zeros, done pulse.

Source files
------------

// File: rtl/systolic_mm_engine.sv
// Output-stationary NxN systolic matrix multiplier: C = A(NxK) * B(KxN), drained one saturated row per handshake.
// Latency: K beats + 2N flush cycles before row 0; in_ready only while loading, each row is held until out_ready.
module systolic_mm_engine #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int CW = 16,
  parameter int KW = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [KW-1:0]          k_len,
  input  logic                   signed_mode,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N*DW-1:0]        a_data,
  input  logic [N*DW-1:0]        b_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N*CW-1:0]        out_data,
  output logic [$clog2(N)-1:0]   out_row,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done,
  output logic                   sat_flag
);

  localparam int ACCW = 2*DW + KW + 1;
  localparam int RW   = $clog2(N);
  localparam int FW   = $clog2(2*N) + 1;
  localparam int PW   = 2*DW + 2;

  localparam logic signed [ACCW-1:0] SMAX = {{(ACCW-CW+1){1'b0}}, {(CW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SMIN = {{(ACCW-CW+1){1'b1}}, {(CW-1){1'b0}}};
  localparam logic signed [ACCW-1:0] UMAX = {{(ACCW-CW){1'b0}}, {CW{1'b1}}};

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

  state_t state, state_nxt;

  logic          accept, clr, in_fire, out_fire;
  logic          last_beat, flush_end, last_row, row_sat;
  logic [KW-1:0] k_lat, beat_cnt;
  logic          sgn;
  logic [FW-1:0] flush_cnt;
  logic [RW-1:0] row_cnt;

  // Input skew lines (lane i taps stage i-1) and the shared per-stage beat valid
  logic [DW-1:0] a_sk [N][N-1];
  logic [DW-1:0] b_sk [N][N-1];
  logic          v_sk [N-1];
  logic [DW-1:0] a_in [N];
  logic [DW-1:0] b_in [N];
  logic          v_in [N];

  // PE array: *_x are operands arriving at PE(i,j), a_h/b_v are the registered hops
  logic [DW-1:0]           a_x  [N][N];
  logic [DW-1:0]           b_x  [N][N];
  logic                    av_x [N][N];
  logic                    bv_x [N][N];
  logic [DW-1:0]           a_h  [N][N];
  logic [DW-1:0]           b_v  [N][N];
  logic                    a_hv [N][N];
  logic                    b_vv [N][N];
  logic signed [PW-1:0]    prod [N][N];
  logic signed [ACCW-1:0]  acc  [N][N];

  assign accept    = start && (state == IDLE);
  assign clr       = rst || accept;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign last_beat = in_fire && (beat_cnt == k_lat - KW'(1));
  assign flush_end = (state == FLUSH) && (flush_cnt == FW'(2*N-1));
  assign last_row  = (row_cnt == RW'(N-1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (k_len == '0) ? DRAIN : LOAD;
      LOAD:    if (last_beat) state_nxt = FLUSH;
      FLUSH:   if (flush_end) state_nxt = DRAIN;
      DRAIN:   if (out_fire && last_row) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE:  busy = 1'b0;
      LOAD:  in_ready = 1'b1;
      DRAIN: begin
        out_valid = 1'b1;
        out_last  = last_row;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_lat     <= '0;
      sgn       <= 1'b0;
      beat_cnt  <= '0;
      flush_cnt <= '0;
      row_cnt   <= '0;
      done      <= 1'b0;
      sat_flag  <= 1'b0;
    end else begin
      done <= out_fire && last_row;
      if (accept) begin
        k_lat     <= k_len;
        sgn       <= signed_mode;
        beat_cnt  <= '0;
        flush_cnt <= '0;
        row_cnt   <= '0;
        sat_flag  <= 1'b0;
      end else begin
        if (in_fire)          beat_cnt  <= beat_cnt + KW'(1);
        if (state == FLUSH)   flush_cnt <= flush_cnt + FW'(1);
        if (out_fire) begin
          row_cnt <= last_row ? '0 : row_cnt + RW'(1);
          if (row_sat) sat_flag <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int d = 0; d < N-1; d++) begin
        v_sk[d] <= 1'b0;
        for (int i = 0; i < N; i++) begin
          a_sk[i][d] <= '0;
          b_sk[i][d] <= '0;
        end
      end
    end else begin
      v_sk[0] <= in_fire;
      for (int d = 1; d < N-1; d++) v_sk[d] <= v_sk[d-1];
      for (int i = 0; i < N; i++) begin
        a_sk[i][0] <= a_data[i*DW +: DW];
        b_sk[i][0] <= b_data[i*DW +: DW];
        for (int d = 1; d < N-1; d++) begin
          a_sk[i][d] <= a_sk[i][d-1];
          b_sk[i][d] <= b_sk[i][d-1];
        end
      end
    end
  end

  always_comb begin
    a_in[0] = a_data[0 +: DW];
    b_in[0] = b_data[0 +: DW];
    v_in[0] = in_fire;
    for (int i = 1; i < N; i++) begin
      a_in[i] = a_sk[i][i-1];
      b_in[i] = b_sk[i][i-1];
      v_in[i] = v_sk[i-1];
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_x[i][0]  = a_in[i];
      av_x[i][0] = v_in[i];
      b_x[0][i]  = b_in[i];
      bv_x[0][i] = v_in[i];
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 1; j < N; j++) begin
        a_x[i][j]  = a_h[i][j-1];
        av_x[i][j] = a_hv[i][j-1];
        b_x[j][i]  = b_v[j-1][i];
        bv_x[j][i] = b_vv[j-1][i];
      end
    end
    // One extra bit per operand makes a single signed multiply serve both modes
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        prod[i][j] = PW'($signed({sgn & a_x[i][j][DW-1], a_x[i][j]}))
                   * PW'($signed({sgn & b_x[i][j][DW-1], b_x[i][j]}));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_h[i][j]  <= '0;
          b_v[i][j]  <= '0;
          a_hv[i][j] <= 1'b0;
          b_vv[i][j] <= 1'b0;
          acc[i][j]  <= '0;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_h[i][j]  <= a_x[i][j];
          b_v[i][j]  <= b_x[i][j];
          a_hv[i][j] <= av_x[i][j];
          b_vv[i][j] <= bv_x[i][j];
          if (av_x[i][j] && bv_x[i][j])
            acc[i][j] <= acc[i][j] + ACCW'(prod[i][j]);
        end
      end
    end
  end

  // Returns {clamped, value}
  function automatic logic [CW:0] saturate(input logic signed [ACCW-1:0] v, input logic s);
    if (s) begin
      if (v > SMAX) return {1'b1, SMAX[CW-1:0]};
      if (v < SMIN) return {1'b1, SMIN[CW-1:0]};
    end else begin
      if (v[ACCW-1]) return {1'b1, {CW{1'b0}}};
      if (v > UMAX)  return {1'b1, UMAX[CW-1:0]};
    end
    return {1'b0, v[CW-1:0]};
  endfunction

  always_comb begin
    logic [CW:0] s_el;
    s_el     = '0;
    row_sat  = 1'b0;
    out_data = '0;
    out_row  = '0;
    if (state == DRAIN) begin
      out_row = row_cnt;
      for (int j = 0; j < N; j++) begin
        s_el = saturate(acc[row_cnt][j], sgn);
        out_data[j*CW +: CW] = s_el[CW-1:0];
        row_sat = row_sat | s_el[CW];
      end
    end
  end

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Self-checking bench: constant vector table, directed corner cases and random jobs against a matrix-product model.
module tb_systolic_mm_engine;

  localparam int N = 4, DW = 8, CW = 16, KW = 8, MAXK = 16;

  logic            clk = 1'b0;
  logic            rst, start, signed_mode, in_valid, out_ready;
  logic [KW-1:0]   k_len;
  logic [N*DW-1:0] a_data, b_data;
  logic            in_ready, out_valid, out_last, busy, done, sat_flag;
  logic [N*CW-1:0] out_data;
  logic [1:0]      out_row;

  systolic_mm_engine #(.N(N), .DW(DW), .CW(CW), .KW(KW)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .signed_mode(signed_mode),
    .in_valid(in_valid), .in_ready(in_ready), .a_data(a_data), .b_data(b_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_row(out_row),
    .out_last(out_last), .busy(busy), .done(done), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  int          am [N][MAXK];
  int          bm [MAXK][N];
  logic [CW-1:0] exp_m [N][N];
  logic [CW-1:0] got   [N][N];
  logic [CW-1:0] ref_got [N][N];
  bit          got_sat;

  typedef struct {
    int          k;
    bit          s;
    int          av;
    int          bv;
    logic [15:0] exp_el;
    bit          exp_sat;
  } vec_t;
  vec_t tbl [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic longint ext(input int v, input bit s);
    return (s && v >= 128) ? longint'(v - 256) : longint'(v);
  endfunction

  // C = A*B in plain integer arithmetic, then clamp to the output range
  task automatic model(input int k, input bit s, output bit sat);
    longint sum;
    sat = 1'b0;
    for (int r = 0; r < N; r++) begin
      for (int j = 0; j < N; j++) begin
        sum = 0;
        for (int kk = 0; kk < k; kk++) sum += ext(am[r][kk], s) * ext(bm[kk][j], s);
        if (s) begin
          if (sum > 32767)       begin sum = 32767;  sat = 1'b1; end
          else if (sum < -32768) begin sum = -32768; sat = 1'b1; end
        end else if (sum > 65535) begin
          sum = 65535; sat = 1'b1;
        end
        exp_m[r][j] = 16'(sum);
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " in_ready"},  in_ready,  0);
    check({tag, " out_valid"}, out_valid, 0);
    check({tag, " busy"},      busy,      0);
    check({tag, " done"},      done,      0);
    check({tag, " sat_flag"},  sat_flag,  0);
    check({tag, " out_data"},  out_data,  0);
    check({tag, " out_row"},   out_row,   0);
    check({tag, " out_last"},  out_last,  0);
  endtask

  // Runs one job from IDLE; called and returns #1 after a rising edge
  task automatic do_job(input int k, input bit s, input bit gaps, input int stall_row,
                        input int stall_cyc, input bit poke_start);
    bit esat, hs;
    int beat, cyc, lat;
    logic [N*CW-1:0] held;
    model(k, s, esat);
    k_len = KW'(k); signed_mode = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; k_len = '1; signed_mode = ~s;
    check("busy after start", busy, 1);
    beat = 0; cyc = 0;
    while (beat < k && cyc < 500) begin
      in_valid = gaps ? ((cyc % 2) == 1) : 1'b1;
      for (int i = 0; i < N; i++) begin
        a_data[i*DW +: DW] = in_valid ? DW'(am[i][beat]) : DW'($urandom);
        b_data[i*DW +: DW] = in_valid ? DW'(bm[beat][i]) : DW'($urandom);
      end
      if (cyc == 0) check("in_ready in load", in_ready, 1);
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      cyc++;
      if (hs) beat++;
    end
    in_valid = 1'b0; a_data = $urandom; b_data = $urandom;
    if (beat < k) check("load beats before timeout", beat, k);
    if (k > 0) check("in_ready after last beat", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 100) begin
      start = poke_start && (lat == 3);
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    check("cycles to first row", lat, (k > 0) ? 2*N : 0);
    for (int r = 0; r < N; r++) begin
      if (r == stall_row) begin
        out_ready = 1'b0;
        held = out_data;
        for (int c = 0; c < stall_cyc; c++) begin
          @(posedge clk); #1;
          check("stalled out_data", out_data, held);
          check("stalled out_row", out_row, r);
        end
      end
      check("out_valid in drain", out_valid, 1);
      check("out_row", out_row, r);
      check("out_last", out_last, r == N-1);
      for (int j = 0; j < N; j++) begin
        got[r][j] = out_data[j*CW +: CW];
        check($sformatf("elem r%0d c%0d", r, j), got[r][j], exp_m[r][j]);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
    check("done pulse", done, 1);
    check("busy at done", busy, 0);
    check("out_valid at done", out_valid, 0);
    check("sat_flag", sat_flag, esat);
    got_sat = sat_flag;
    @(posedge clk); #1;
    check("done one cycle", done, 0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++)
      for (int kk = 0; kk < MAXK; kk++) begin
        am[i][kk] = int'($urandom_range(0, 255));
        bm[kk][i] = int'($urandom_range(0, 255));
      end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit s;
    tbl[0] = '{k:4, s:1, av:127, bv:127, exp_el:16'h7FFF, exp_sat:1};
    tbl[1] = '{k:4, s:1, av:128, bv:127, exp_el:16'h8000, exp_sat:1};
    tbl[2] = '{k:1, s:0, av:255, bv:255, exp_el:16'hFE01, exp_sat:0};
    tbl[3] = '{k:2, s:1, av:255, bv:255, exp_el:16'h0002, exp_sat:0};
    tbl[4] = '{k:3, s:0, av:10,  bv:20,  exp_el:16'h0258, exp_sat:0};
    tbl[5] = '{k:0, s:1, av:5,   bv:5,   exp_el:16'h0000, exp_sat:0};
    tbl[6] = '{k:4, s:1, av:255, bv:127, exp_el:16'hFE04, exp_sat:0};
    tbl[7] = '{k:2, s:0, av:200, bv:200, exp_el:16'hFFFF, exp_sat:1};

    rst = 1'b1; start = 1'b0; k_len = '0; signed_mode = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; a_data = '0; b_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Identity A: rows of C are the rows of B
    for (int i = 0; i < N; i++)
      for (int kk = 0; kk < MAXK; kk++) begin
        am[i][kk] = (i == kk) ? 1 : 0;
        bm[kk][i] = kk*4 + i;
      end
    do_job(4, 1, 0, -1, 0, 0);
    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++)
        check($sformatf("identity r%0d c%0d", r, j), got[r][j], r*4 + j);
    check("identity sat_flag", got_sat, 0);

    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < N; i++)
        for (int kk = 0; kk < MAXK; kk++) begin
          am[i][kk] = tbl[t].av;
          bm[kk][i] = tbl[t].bv;
        end
      do_job(tbl[t].k, tbl[t].s, 0, -1, 0, 0);
      for (int r = 0; r < N; r++)
        for (int j = 0; j < N; j++)
          check($sformatf("table%0d r%0d c%0d", t, r, j), got[r][j], tbl[t].exp_el);
      check($sformatf("table%0d sat_flag", t), got_sat, tbl[t].exp_sat);
    end

    // Input bubbles and a 5-cycle stall on row 1 must not change the result
    fill_random();
    s = 1'($urandom_range(0, 1));
    do_job(3, s, 0, -1, 0, 0);
    ref_got = got;
    do_job(3, s, 1, 1, 5, 0);
    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++)
        check($sformatf("gap vs gapfree r%0d c%0d", r, j), got[r][j], ref_got[r][j]);

    // Reset in the middle of loading, then a fresh job with a start poked during FLUSH
    fill_random();
    k_len = 8'd4; signed_mode = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int b = 0; b < 2; b++) begin
      in_valid = 1'b1;
      a_data = $urandom; b_data = $urandom;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_idle_outputs("mid-load reset");
    rst = 1'b0;
    @(posedge clk); #1;
    fill_random();
    do_job(2, 1, 0, -1, 0, 1);

    for (int t = 0; t < 10; t++) begin
      fill_random();
      do_job(int'($urandom_range(0, 8)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 4)) - 1, int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
